// File: rtl/result_streamer_pkg.sv
// rtl/result_streamer_pkg.sv - shared types and helpers for the result streamer
package result_streamer_pkg;

    typedef enum logic {
        ORDER_BLOCKED = 1'b0,
        ORDER_RASTER  = 1'b1
    } order_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 2;

    function automatic int block_count(input int half, input int blocking);
        return (half + blocking - 1) / blocking;
    endfunction

    // Width of a counter that walks 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_streamer_if.sv
// rtl/result_streamer_if.sv - result memory read port and output FIFO write port
interface result_streamer_if #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 9
);
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_fifo_wenq;
    logic [DATA_WIDTH-1:0] out_fifo_wdata;
    logic [ADDR_WIDTH-1:0] out_fifo_waddr;
    logic                  out_fifo_wfull_n;

    modport master (
        output mem_ren,
        output mem_raddr,
        input  mem_rdata,
        output out_fifo_wenq,
        output out_fifo_wdata,
        output out_fifo_waddr,
        input  out_fifo_wfull_n
    );

    modport slave (
        input  mem_ren,
        input  mem_raddr,
        output mem_rdata,
        input  out_fifo_wenq,
        input  out_fifo_wdata,
        input  out_fifo_waddr,
        output out_fifo_wfull_n
    );
endinterface

// File: rtl/result_addr_gen.sv
// rtl/result_addr_gen.sv - blocked-strip / raster address sequencer with next/last handshake
module result_addr_gen
    import result_streamer_pkg::*;
#(
    parameter int ROW_SIZE     = 26,
    parameter int COL_SIZE     = 19,
    parameter int NUM_PORTIONS = 2,
    parameter int BLOCKING     = 4,
    parameter int ADDR_WIDTH   = $clog2(ROW_SIZE * COL_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  order_mode_e           mode,
    input  logic                  next,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam int HALF       = ROW_SIZE / NUM_PORTIONS;
    localparam int NUM_BLOCKS = block_count(HALF, BLOCKING);
    localparam int PX_W       = cnt_width(NUM_PORTIONS);
    localparam int XB_W       = cnt_width(NUM_BLOCKS);
    localparam int Y_W        = cnt_width(COL_SIZE);
    localparam int XI_W       = cnt_width(BLOCKING);
    localparam int COL_W      = cnt_width(HALF);

    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(NUM_PORTIONS - 1);
    localparam logic [XB_W-1:0]  XB_LAST  = XB_W'(NUM_BLOCKS - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(COL_SIZE - 1);
    localparam logic [XI_W-1:0]  XI_LAST  = XI_W'(BLOCKING - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(HALF - 1);
    localparam logic [COL_W-1:0] COL_STEP = COL_W'(BLOCKING);

    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ROW  = ADDR_WIDTH'(ROW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] A_HALF = ADDR_WIDTH'(HALF);
    localparam logic [ADDR_WIDTH-1:0] A_BLK  = ADDR_WIDTH'(BLOCKING);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(ROW_SIZE * COL_SIZE - 1);

    order_mode_e           mode_q;
    logic [PX_W-1:0]       px;
    logic [XB_W-1:0]       xb;
    logic [Y_W-1:0]        y;
    logic [XI_W-1:0]       xi;
    logic [COL_W-1:0]      col;
    logic [COL_W-1:0]      col_base;
    logic [ADDR_WIDTH-1:0] strip_base;
    logic [ADDR_WIDTH-1:0] blk_base;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  xi_wrap, y_wrap, xb_wrap, px_wrap;
    logic [ADDR_WIDTH-1:0] row_next, blk_next, strip_next;
    logic [COL_W-1:0]      col_base_next;

    // A row segment ends at the block edge or at the strip edge, whichever
    // comes first, so ragged last block columns are skipped for free.
    assign xi_wrap = (xi == XI_LAST) || (col == COL_LAST);
    assign y_wrap  = (y == Y_LAST);
    assign xb_wrap = (xb == XB_LAST);
    assign px_wrap = (px == PX_LAST);

    assign row_next      = row_base + A_ROW;
    assign blk_next      = blk_base + A_BLK;
    assign strip_next    = strip_base + A_HALF;
    assign col_base_next = col_base + COL_STEP;

    assign addr = addr_q;
    assign last = (mode_q == ORDER_RASTER) ? (addr_q == A_LAST)
                                           : (xi_wrap && y_wrap && xb_wrap && px_wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= ORDER_BLOCKED;
            px         <= '0;
            xb         <= '0;
            y          <= '0;
            xi         <= '0;
            col        <= '0;
            col_base   <= '0;
            strip_base <= '0;
            blk_base   <= '0;
            row_base   <= '0;
            addr_q     <= '0;
        end else if (init) begin
            mode_q     <= mode;
            px         <= '0;
            xb         <= '0;
            y          <= '0;
            xi         <= '0;
            col        <= '0;
            col_base   <= '0;
            strip_base <= '0;
            blk_base   <= '0;
            row_base   <= '0;
            addr_q     <= '0;
        end else if (next && !last) begin
            if (mode_q == ORDER_RASTER) begin
                addr_q <= addr_q + A_ONE;
            end else if (!xi_wrap) begin
                xi     <= xi + XI_W'(1);
                col    <= col + COL_W'(1);
                addr_q <= addr_q + A_ONE;
            end else if (!y_wrap) begin
                xi       <= '0;
                col      <= col_base;
                y        <= y + Y_W'(1);
                row_base <= row_next;
                addr_q   <= row_next;
            end else if (!xb_wrap) begin
                xi       <= '0;
                y        <= '0;
                xb       <= xb + XB_W'(1);
                col_base <= col_base_next;
                col      <= col_base_next;
                blk_base <= blk_next;
                row_base <= blk_next;
                addr_q   <= blk_next;
            end else begin
                xi         <= '0;
                y          <= '0;
                xb         <= '0;
                col        <= '0;
                col_base   <= '0;
                px         <= px + PX_W'(1);
                strip_base <= strip_next;
                blk_base   <= strip_next;
                row_base   <= strip_next;
                addr_q     <= strip_next;
            end
        end
    end

endmodule

// File: rtl/result_streamer.sv
// rtl/result_streamer.sv - streams result memory words to the output FIFO in blocked or raster order
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int DATA_WIDTH   = 11,
    parameter int ROW_SIZE     = 26,
    parameter int COL_SIZE     = 19,
    parameter int NUM_PORTIONS = 2,
    parameter int BLOCKING     = 4,
    parameter int ADDR_WIDTH   = $clog2(ROW_SIZE * COL_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              order_mode,
    output logic              busy,
    output logic              done,
    result_streamer_if.master bus
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]            state;
    logic [1:0]            sk_count;
    logic                  sk_wr_ptr;
    logic                  sk_rd_ptr;
    logic [DATA_WIDTH-1:0] sk_data [SKID_DEPTH];
    logic [ADDR_WIDTH-1:0] sk_tag  [SKID_DEPTH];
    logic                  rd_pending;
    logic [ADDR_WIDTH-1:0] pend_tag;

    logic                  gen_init;
    logic                  gen_last;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  deq;
    logic                  issue;
    logic                  drain_empty;

    result_addr_gen #(
        .ROW_SIZE     (ROW_SIZE),
        .COL_SIZE     (COL_SIZE),
        .NUM_PORTIONS (NUM_PORTIONS),
        .BLOCKING     (BLOCKING),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (gen_init),
        .mode  (order_mode_e'(order_mode)),
        .next  (issue),
        .addr  (gen_addr),
        .last  (gen_last)
    );

    assign gen_init    = (state == IDLE) && start;
    assign deq         = (sk_count != 2'd0) && bus.out_fifo_wfull_n;
    assign drain_empty = (sk_count == 2'd0) && !rd_pending;

    // Credit check: occupancy plus the read already in flight, less the word
    // leaving this cycle, must leave a slot for a read issued now.
    assign issue = (state == RUN) &&
                   (({1'b0, sk_count} + {2'b00, rd_pending}) <= ({2'b00, deq} + 3'd1));

    assign busy = (state != IDLE);
    assign done = (state == DRAIN) && drain_empty;

    assign bus.mem_ren        = issue;
    assign bus.mem_raddr      = gen_addr;
    assign bus.out_fifo_wenq  = deq;
    assign bus.out_fifo_wdata = sk_data[sk_rd_ptr];
    assign bus.out_fifo_waddr = sk_tag[sk_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (issue && gen_last) state <= DRAIN;
                DRAIN:   if (drain_empty) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            pend_tag   <= '0;
            sk_count   <= 2'd0;
            sk_wr_ptr  <= 1'b0;
            sk_rd_ptr  <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                sk_data[i] <= '0;
                sk_tag[i]  <= '0;
            end
        end else begin
            rd_pending <= issue;
            if (issue) begin
                pend_tag <= gen_addr;
            end
            if (rd_pending) begin
                sk_data[sk_wr_ptr] <= bus.mem_rdata;
                sk_tag[sk_wr_ptr]  <= pend_tag;
                sk_wr_ptr          <= ~sk_wr_ptr;
            end
            if (deq) begin
                sk_rd_ptr <= ~sk_rd_ptr;
            end
            case ({rd_pending, deq})
                2'b10:   sk_count <= sk_count + 2'd1;
                2'b01:   sk_count <= sk_count - 2'd1;
                default: sk_count <= sk_count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// tb/tb_result_streamer.sv - scoreboard bench for result_streamer (BLOCKING 4 and 5 instances)
module tb_result_streamer;

    localparam int DW    = 11;
    localparam int AW    = 9;
    localparam int RS    = 26;
    localparam int CS    = 19;
    localparam int HALF  = 13;
    localparam int TOTAL = RS * CS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, order0 = 1'b0, busy0, done0;
    logic start1 = 1'b0, order1 = 1'b0, busy1, done1;

    always #5 clk = ~clk;

    result_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
    result_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

    result_streamer #(.DATA_WIDTH(DW), .ROW_SIZE(RS), .COL_SIZE(CS), .NUM_PORTIONS(2),
                      .BLOCKING(4), .ADDR_WIDTH(AW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .order_mode(order0),
        .busy(busy0), .done(done0), .bus(if0));

    result_streamer #(.DATA_WIDTH(DW), .ROW_SIZE(RS), .COL_SIZE(CS), .NUM_PORTIONS(2),
                      .BLOCKING(5), .ADDR_WIDTH(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .order_mode(order1),
        .busy(busy1), .done(done1), .bus(if1));

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int q0[$], q1[$];
    int obs0[$], obs1[$];
    int cyc0[$];
    int done_n0 = 0, done_n1 = 0;

    function automatic logic [DW-1:0] mem_val(input int a);
        return DW'((a * 37 + 5) % 2048);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if0.mem_rdata <= if0.mem_ren ? mem_val(int'(if0.mem_raddr)) : DW'($urandom);
        if1.mem_rdata <= if1.mem_ren ? mem_val(int'(if1.mem_raddr)) : DW'($urandom);
    end

    always @(negedge clk) begin
        int e;
        if (if0.out_fifo_wenq === 1'b1) begin
            check("wenq_while_full0", if0.out_fifo_wfull_n, 1);
            check("sb_nonempty0", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("tag0", if0.out_fifo_waddr, e);
                check("data0", if0.out_fifo_wdata, mem_val(e));
            end
            obs0.push_back(int'(if0.out_fifo_waddr));
            cyc0.push_back(cyc);
        end
        if (if1.out_fifo_wenq === 1'b1) begin
            check("wenq_while_full1", if1.out_fifo_wfull_n, 1);
            check("sb_nonempty1", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("tag1", if1.out_fifo_waddr, e);
                check("data1", if1.out_fifo_wdata, mem_val(e));
            end
            obs1.push_back(int'(if1.out_fifo_waddr));
        end
        if (done0 === 1'b1) done_n0++;
        if (done1 === 1'b1) done_n1++;
    end

    task automatic push_seq(input int dut, input int mode, input int blk);
        int nb;
        int c;
        int a;
        nb = (HALF + blk - 1) / blk;
        if (mode == 1) begin
            for (int i = 0; i < TOTAL; i++) begin
                if (dut == 0) q0.push_back(i); else q1.push_back(i);
            end
        end else begin
            for (int px = 0; px < 2; px++)
                for (int xb = 0; xb < nb; xb++)
                    for (int y = 0; y < CS; y++)
                        for (int xi = 0; xi < blk; xi++) begin
                            c = xb * blk + xi;
                            if (c < HALF) begin
                                a = px * HALF + y * RS + c;
                                if (dut == 0) q0.push_back(a); else q1.push_back(a);
                            end
                        end
        end
    endtask

    // Mode is flipped right after the sampling edge; the run must not notice.
    task automatic pulse_start(input int dut, input logic mode);
        @(posedge clk); #1;
        if (dut == 0) begin order0 = mode; start0 = 1'b1; end
        else begin order1 = mode; start1 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (dut == 0) order0 = ~mode; else order1 = ~mode;
    endtask

    task automatic wait_done(input int dut, input int base_done, input string tag);
        int n = 0;
        while (((dut == 0) ? done_n0 : done_n1) == base_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, ((dut == 0) ? done_n0 : done_n1) != base_done, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bd, lat, sz, n;
        int exp8[8];
        exp8 = '{0, 1, 2, 3, 26, 27, 28, 29};
        if0.out_fifo_wfull_n = 1'b1;
        if1.out_fifo_wfull_n = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_mem_ren", if0.mem_ren, 0);
        check("rst_mem_raddr", if0.mem_raddr, 0);
        check("rst_wenq", if0.out_fifo_wenq, 0);
        check("rst_wdata", if0.out_fifo_wdata, 0);
        check("rst_waddr", if0.out_fifo_waddr, 0);
        check("rst_busy1", busy1, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Blocked order, FIFO always ready
        base = obs0.size(); bd = done_n0;
        push_seq(0, 0, 4);
        pulse_start(0, 1'b0);
        lat = 0;
        @(negedge clk);
        while (if0.out_fifo_wenq !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        check("first_latency", lat, 2);
        wait_done(0, bd, "done_blocked");
        check("count_blocked", obs0.size() - base, TOTAL);
        check("done_once_blocked", done_n0 - bd, 1);
        check("sb_empty_blocked", q0.size(), 0);
        check("busy_after_blocked", busy0, 0);
        for (int i = 0; i < 8; i++) check("first_addrs", obs0[base + i], exp8[i]);
        check("xb3_y0", obs0[base + 228], 12);
        check("xb3_y1", obs0[base + 229], 38);
        check("xb3_y2", obs0[base + 230], 64);
        check("px1_start", obs0[base + 247], 13);
        check("rate_blocked", cyc0[base + TOTAL - 1] - cyc0[base], TOTAL - 1);

        // Raster order
        base = obs0.size(); bd = done_n0;
        push_seq(0, 1, 4);
        pulse_start(0, 1'b1);
        wait_done(0, bd, "done_raster");
        check("count_raster", obs0.size() - base, TOTAL);
        check("done_once_raster", done_n0 - bd, 1);
        check("raster_last_tag", obs0[base + TOTAL - 1], TOTAL - 1);
        check("rate_raster", cyc0[base + TOTAL - 1] - cyc0[base], TOTAL - 1);

        // Back-pressure: 10-cycle stall then random toggling
        base = obs0.size(); bd = done_n0;
        push_seq(0, 0, 4);
        pulse_start(0, 1'b0);
        repeat (40) @(posedge clk);
        #1 if0.out_fifo_wfull_n = 1'b0;
        @(negedge clk);
        sz = obs0.size();
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("stall_hold", obs0.size() - sz, 0);
        n = 0;
        while (done_n0 == bd && n < 5000) begin
            @(posedge clk); #1;
            if0.out_fifo_wfull_n = 1'($urandom_range(0, 1));
            n++;
        end
        if0.out_fifo_wfull_n = 1'b1;
        check("done_backpressure", done_n0 != bd, 1);
        repeat (4) @(negedge clk);
        check("count_backpressure", obs0.size() - base, TOTAL);
        check("sb_empty_backpressure", q0.size(), 0);
        check("done_once_backpressure", done_n0 - bd, 1);

        // BLOCKING=5 instance
        base = obs1.size(); bd = done_n1;
        push_seq(1, 0, 5);
        pulse_start(1, 1'b0);
        wait_done(1, bd, "done_blk5");
        check("count_blk5", obs1.size() - base, TOTAL);
        check("blk5_xb2_xi0", obs1[base + 190], 10);
        check("blk5_xb2_xi1", obs1[base + 191], 11);
        check("blk5_xb2_xi2", obs1[base + 192], 12);
        check("blk5_xb2_y1", obs1[base + 193], 36);
        check("blk5_px1_start", obs1[base + 247], 13);
        check("done_once_blk5", done_n1 - bd, 1);

        // Reset in the middle of a run
        base = obs0.size();
        push_seq(0, 0, 4);
        pulse_start(0, 1'b0);
        n = 0;
        while (obs0.size() - base < 100 && n < 1000) begin @(negedge clk); n++; end
        check("reached_100", obs0.size() - base >= 100, 1);
        #1 rst_n = 1'b0;
        q0.delete();
        repeat (3) @(negedge clk);
        check("midrst_busy", busy0, 0);
        check("midrst_wenq", if0.out_fifo_wenq, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        sz = obs0.size();
        repeat (8) @(negedge clk);
        check("no_enq_after_reset", obs0.size() - sz, 0);
        check("idle_after_reset", busy0, 0);
        base = obs0.size(); bd = done_n0;
        push_seq(0, 0, 4);
        pulse_start(0, 1'b0);
        wait_done(0, bd, "done_after_reset");
        check("count_after_reset", obs0.size() - base, TOTAL);
        check("first_after_reset", obs0[base], 0);
        check("done_once_after_reset", done_n0 - bd, 1);

        // Repeated start pulses with mode changes while running
        base = obs0.size(); bd = done_n0;
        push_seq(0, 0, 4);
        pulse_start(0, 1'b0);
        repeat (30) @(posedge clk);
        pulse_start(0, 1'b1);
        repeat (50) @(posedge clk);
        pulse_start(0, 1'b1);
        repeat (50) @(posedge clk);
        pulse_start(0, 1'b0);
        wait_done(0, bd, "done_restart");
        repeat (20) @(negedge clk);
        check("count_restart", obs0.size() - base, TOTAL);
        check("done_once_restart", done_n0 - bd, 1);
        check("sb_empty_restart", q0.size(), 0);
        check("busy_after_restart", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
